instr_fetch_unit: RTL

- Consumer-side partner of the program counter in the multicycle CPU.
- Takes the current PC value and, on a fetch command from the control FSM, performs a handshaked word read from instruction memory.
- Latches the returned word into the instruction register (IR).
- Emits a one-cycle PC write-enable with the sequential next PC (PC+4).
- Flags misaligned fetches and memory timeouts instead of hanging the CPU.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_timeout_ctr.sv | 39 +++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU front end: default widths,
// sequential PC increment and the fetch FSM encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PC_INCR = 4;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Clear/enable counter that raises o_expire once it has counted TIMEOUT-1
// un-acknowledged request cycles; it saturates there until cleared.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        o_expire = (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && !o_expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: handshaked word read of the current PC into the IR,
// with a one-cycle PC write-enable carrying PC+4, and misalign/timeout errors.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
    parameter int unsigned DATA_W  = cpu_pkg::DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fetch_start,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_ir,
    output logic              o_ir_valid,
    output logic              o_pc_w_c,
    output logic [ADDR_W-1:0] o_next_pc,
    output logic              o_busy,
    output logic              o_fetch_err
);

    import cpu_pkg::*;

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] ir_q;
    logic              ir_valid_q;
    logic [ADDR_W-1:0] next_pc_q;
    logic              pc_w_c_q;
    logic              fetch_err_q;
    logic              aligned;
    logic              expire;

    assign aligned = (i_pc[1:0] == 2'b00);

    fetch_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (state_q == IDLE),
        .i_en    ((state_q == REQ) && !i_mem_ack),
        .o_expire(expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_fetch_start && aligned) state_d = REQ;
            REQ:     if (i_mem_ack || expire)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ack takes priority over expiry, so a word arriving on the last allowed cycle is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q      <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            next_pc_q   <= '0;
            pc_w_c_q    <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            pc_w_c_q    <= 1'b0;
            fetch_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_fetch_start) begin
                        ir_valid_q <= 1'b0;
                        if (aligned) begin
                            addr_q <= i_pc;
                        end else begin
                            fetch_err_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (i_mem_ack) begin
                        ir_q       <= i_mem_rdata;
                        ir_valid_q <= 1'b1;
                        next_pc_q  <= addr_q + ADDR_W'(PC_INCR);
                        pc_w_c_q   <= 1'b1;
                    end else if (expire) begin
                        fetch_err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_mem_req   = (state_q == REQ);
        o_busy      = (state_q == REQ);
        o_mem_addr  = addr_q;
        o_ir        = ir_q;
        o_ir_valid  = ir_valid_q;
        o_next_pc   = next_pc_q;
        o_pc_w_c    = pc_w_c_q;
        o_fetch_err = fetch_err_q;
    end

endmodule
